// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes: streams 16 masked state bytes through one external pipelined
// masked S-box and reassembles the results for shift_rows.
package clm_pkg;
  localparam int D_SHARES = 2;
endpackage

// state | meaning
// IDLE  | waiting for a state, in_ready=1
// RUN   | issuing bytes column-major and capturing S-box results
// DONE  | out_state complete, held until out_ready
module sub_bytes_seq #(
  parameter int d        = clm_pkg::D_SHARES,
  parameter int SBOX_LAT = 4,
  parameter int RND_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0][3:0][d-1:0][7:0] in_state,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [3:0][3:0][d-1:0][7:0] out_state,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [d-1:0][7:0]           sbox_in,
  output logic                        sbox_valid,
  input  logic [d-1:0][7:0]           sbox_out,
  input  logic [RND_W-1:0]            rnd_in,
  output logic                        rnd_req
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                        state_q;
  logic [3:0][3:0][d-1:0][7:0] work_q;
  logic [3:0]                  issue_cnt;
  logic [3:0]                  cap_cnt;
  logic [SBOX_LAT-1:0]         tok_q;
  logic                        tok_exit;
  logic [3:0]                  issue_nxt;

  // randomness is consumed by the S-box itself; this block only requests it
  logic                        unused_rnd;
  assign unused_rnd = ^rnd_in;

  assign tok_exit  = tok_q[SBOX_LAT-1];
  assign issue_nxt = issue_cnt + 4'd1;
  assign in_ready  = (state_q == IDLE);
  assign rnd_req   = sbox_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      tok_q      <= '0;
      out_state  <= '0;
      out_valid  <= 1'b0;
      sbox_in    <= '0;
      sbox_valid <= 1'b0;
    end else begin
      tok_q[0] <= sbox_valid;
      for (int i = 1; i < SBOX_LAT; i++) tok_q[i] <= tok_q[i-1];

      // a token leaving the pipe marks the cycle its S-box result is on sbox_out
      if (tok_exit) begin
        out_state[cap_cnt[1:0]][cap_cnt[3:2]] <= sbox_out;
        cap_cnt <= cap_cnt + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_state;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            sbox_in    <= in_state[0][0];
            sbox_valid <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (sbox_valid && issue_cnt != 4'd15) begin
            issue_cnt <= issue_nxt;
            sbox_in   <= work_q[issue_nxt[1:0]][issue_nxt[3:2]];
          end else begin
            sbox_valid <= 1'b0;
            sbox_in    <= '0;
          end
          if (tok_exit && cap_cnt == 4'd15) begin
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
